// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the register file with load queue.
package reg_file_pkg;

  // Entry address is stored at a fixed maximum width; only the low D bits carry meaning.
  localparam int D_MAX = 8;

  typedef struct packed {
    logic             valid;
    logic             kill;
    logic [D_MAX-1:0] addr;
  } lq_entry_t;

  function automatic int ptr_w(input int lq);
    return (lq > 1) ? $clog2(lq) : 1;
  endfunction

endpackage

// File: rtl/reg_file_lq_if.sv
// Decode/execute and memory-return bus of the register file.
interface reg_file_lq_if #(
  parameter int W   = 8,
  parameter int D   = 4,
  parameter int NRD = 2,
  parameter int LQ  = 4
);
  localparam int CW = $clog2(LQ + 1);

  logic [NRD*D-1:0] Raddr;
  logic [NRD*W-1:0] DataOut;
  logic [NRD-1:0]   RdBusy;
  logic             WriteEn;
  logic [D-1:0]     Waddr;
  logic [W-1:0]     DataIn;
  logic             WaddrBusy;
  logic             LoadIssue;
  logic [D-1:0]     LoadAddr;
  logic             LoadIssueReady;
  logic             LoadRet;
  logic [W-1:0]     LoadData;
  logic [CW-1:0]    LoadCount;
  logic             Err;

  modport master (
    output Raddr, WriteEn, Waddr, DataIn, LoadIssue, LoadAddr, LoadRet, LoadData,
    input  DataOut, RdBusy, WaddrBusy, LoadIssueReady, LoadCount, Err
  );

  modport slave (
    input  Raddr, WriteEn, Waddr, DataIn, LoadIssue, LoadAddr, LoadRet, LoadData,
    output DataOut, RdBusy, WaddrBusy, LoadIssueReady, LoadCount, Err
  );
endinterface

// File: rtl/reg_file_lq_load_queue.sv
// In-order queue of outstanding load destinations with kill-by-address,
// live-head detection and a per-register busy view of the pre-update state.
module load_queue
  import reg_file_pkg::*;
#(
  parameter int D       = 4,
  parameter int LQ      = 4,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_en,
  input  logic [D-1:0]             waddr,
  input  logic                     issue,
  input  logic [D-1:0]             issue_addr,
  input  logic                     ret,
  output logic                     head_live,
  output logic [D-1:0]             head_addr,
  output logic [$clog2(LQ+1)-1:0]  count,
  output logic                     full,
  output logic                     empty,
  output logic [2**D-1:0]          busy
);
  localparam int PW = ptr_w(LQ);
  localparam int CW = $clog2(LQ + 1);

  lq_entry_t     q [LQ];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic [LQ-1:0] kill_now;
  logic          push;
  logic          pop;

  always_comb begin
    empty = (cnt == '0);
    full  = (cnt == CW'(LQ));
    pop   = ret & ~empty;
    push  = issue & ~full;
    // A rejected issue kills nothing; an accepted one supersedes older loads to its address.
    for (int i = 0; i < LQ; i++) begin
      kill_now[i] = q[i].valid &
                    ((write_en & (q[i].addr == D_MAX'(waddr))) |
                     (push & (q[i].addr == D_MAX'(issue_addr))));
    end
    head_live = pop & q[head].valid & ~q[head].kill & ~kill_now[head];
    head_addr = q[head].addr[D-1:0];
    count     = cnt;
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < LQ; i++) begin
      if (q[i].valid && !q[i].kill) busy[q[i].addr[D-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < LQ; i++) begin
        q[i].valid <= 1'b0;
        q[i].kill  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LQ; i++) q[i].kill <= q[i].kill | kill_now[i];
      if (pop) q[head].valid <= 1'b0;
      if (push) begin
        q[tail].valid <= 1'b1;
        q[tail].kill  <= (ZERO_R0 != 0) && (issue_addr == '0);
        q[tail].addr  <= D_MAX'(issue_addr);
      end
      head <= head + PW'(pop);
      tail <= tail + PW'(push);
      cnt  <= cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/reg_file_lq.sv
// Register file with N combinational read ports, ALU write port, load-return
// port fed by an in-order load queue, busy scoreboard and write bypass.
module reg_file_lq
  import reg_file_pkg::*;
#(
  parameter int W       = 8,
  parameter int D       = 4,
  parameter int NRD     = 2,
  parameter int LQ      = 4,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  reg_file_lq_if.slave  bus
);
  localparam int NR = 2**D;
  localparam int CW = $clog2(LQ + 1);

  logic [W-1:0]   rf [NR];
  logic           head_live;
  logic [D-1:0]   head_addr;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic [NR-1:0]  busy;
  logic           alu_we;
  logic           err_q;

  load_queue #(.D(D), .LQ(LQ), .ZERO_R0(ZERO_R0)) u_lq (
    .clk        (Clk),
    .rst        (Reset),
    .write_en   (bus.WriteEn),
    .waddr      (bus.Waddr),
    .issue      (bus.LoadIssue),
    .issue_addr (bus.LoadAddr),
    .ret        (bus.LoadRet),
    .head_live  (head_live),
    .head_addr  (head_addr),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .busy       (busy)
  );

  assign alu_we = bus.WriteEn & ~((ZERO_R0 != 0) && (bus.Waddr == '0));

  // ALU write is applied last so it wins over a load return to the same register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < NR; k++) rf[k] <= '0;
      err_q <= 1'b0;
    end else begin
      if (head_live) rf[head_addr] <= bus.LoadData;
      if (alu_we) rf[bus.Waddr] <= bus.DataIn;
      if ((bus.LoadRet && empty) || (bus.LoadIssue && full)) err_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [D-1:0] ra;
    logic [W-1:0] rd;
    assign ra = bus.Raddr[i*D +: D];
    always_comb begin
      rd = rf[ra];
      if ((BYPASS != 0) && head_live && (head_addr == ra)) rd = bus.LoadData;
      if ((BYPASS != 0) && alu_we && (bus.Waddr == ra)) rd = bus.DataIn;
      if ((ZERO_R0 != 0) && (ra == '0)) rd = '0;
    end
    assign bus.DataOut[i*W +: W] = rd;
    assign bus.RdBusy[i]         = busy[ra];
  end

  assign bus.WaddrBusy      = busy[bus.Waddr];
  assign bus.LoadIssueReady = ~full;
  assign bus.LoadCount      = count;
  assign bus.Err            = err_q;

endmodule

// File: tb/tb_reg_file_lq.sv
// Bench for reg_file_lq: two instances (ZERO_R0=0 and 1) driven in lockstep and
// checked every cycle against a queue-based reference model.
module tb_reg_file_lq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_lq_if #(.W(8), .D(4), .NRD(2), .LQ(4)) if0 ();
  reg_file_lq_if #(.W(8), .D(4), .NRD(2), .LQ(4)) if1 ();

  reg_file_lq #(.W(8), .D(4), .NRD(2), .LQ(4), .ZERO_R0(0), .BYPASS(1)) dut0 (
    .Clk(clk), .Reset(rst), .bus(if0));
  reg_file_lq #(.W(8), .D(4), .NRD(2), .LQ(4), .ZERO_R0(1), .BYPASS(1)) dut1 (
    .Clk(clk), .Reset(rst), .bus(if1));

  typedef struct packed {
    logic       live;
    logic [3:0] addr;
  } ment_t;

  ment_t      mq[$];
  logic [7:0] mrf [16];
  logic       merr;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         stepn = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic mbusy(input int z, input logic [3:0] a);
    foreach (mq[k]) if (mq[k].live && mq[k].addr == a && !(z == 1 && a == 4'd0)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mreset();
    mq.delete();
    for (int k = 0; k < 16; k++) mrf[k] = 8'h00;
    merr = 1'b0;
  endtask

  // One clock cycle: apply inputs, check both DUTs mid-cycle, advance the model.
  task automatic step(input logic rs, input logic we, input logic [3:0] wa, input logic [7:0] din,
                      input logic iss, input logic [3:0] ia, input logic ret, input logic [7:0] ld,
                      input logic [3:0] r0a, input logic [3:0] r1a,
                      input int e0, input int e1, input int ec, input int ee);
    logic [15:0] od [2];
    logic [1:0]  ob [2];
    logic        owb [2], ordy [2], oe [2];
    logic [2:0]  oc [2];
    logic [3:0]  ra;
    logic [7:0]  exp_d;
    logic        acc, fl;
    logic [3:0]  fa;
    int          sz;
    rst = rs;
    if0.WriteEn = we;  if0.Waddr = wa;  if0.DataIn = din;
    if0.LoadIssue = iss; if0.LoadAddr = ia; if0.LoadRet = ret; if0.LoadData = ld;
    if0.Raddr = {r1a, r0a};
    if1.WriteEn = we;  if1.Waddr = wa;  if1.DataIn = din;
    if1.LoadIssue = iss; if1.LoadAddr = ia; if1.LoadRet = ret; if1.LoadData = ld;
    if1.Raddr = {r1a, r0a};
    stepn++;
    @(negedge clk);
    od[0] = if0.DataOut; ob[0] = if0.RdBusy; owb[0] = if0.WaddrBusy;
    oc[0] = if0.LoadCount; ordy[0] = if0.LoadIssueReady; oe[0] = if0.Err;
    od[1] = if1.DataOut; ob[1] = if1.RdBusy; owb[1] = if1.WaddrBusy;
    oc[1] = if1.LoadCount; ordy[1] = if1.LoadIssueReady; oe[1] = if1.Err;
    sz = mq.size();
    for (int z = 0; z < 2; z++) begin
      chk($sformatf("s%0d d%0d RdBusy0", stepn, z), 32'(ob[z][0]), 32'(mbusy(z, r0a)));
      chk($sformatf("s%0d d%0d RdBusy1", stepn, z), 32'(ob[z][1]), 32'(mbusy(z, r1a)));
      chk($sformatf("s%0d d%0d WaddrBusy", stepn, z), 32'(owb[z]), 32'(mbusy(z, wa)));
      chk($sformatf("s%0d d%0d LoadCount", stepn, z), 32'(oc[z]), 32'(sz));
      chk($sformatf("s%0d d%0d Ready", stepn, z), 32'(ordy[z]), 32'(sz < 4));
      chk($sformatf("s%0d d%0d Err", stepn, z), 32'(oe[z]), 32'(merr));
    end
    acc = iss && (sz < 4);
    foreach (mq[k]) begin
      if ((we && mq[k].addr == wa) || (acc && mq[k].addr == ia)) mq[k].live = 1'b0;
    end
    fl = ret && (sz > 0) && mq[0].live;
    fa = (sz > 0) ? mq[0].addr : 4'd0;
    for (int z = 0; z < 2; z++) begin
      for (int p = 0; p < 2; p++) begin
        ra = (p == 0) ? r0a : r1a;
        if (z == 1 && ra == 4'd0)      exp_d = 8'h00;
        else if (we && wa == ra)       exp_d = din;
        else if (fl && fa == ra)       exp_d = ld;
        else                           exp_d = mrf[ra];
        chk($sformatf("s%0d d%0d DataOut%0d", stepn, z, p), 32'(od[z][p*8 +: 8]), 32'(exp_d));
      end
    end
    if (e0 >= 0) chk($sformatf("s%0d d0 directed read", stepn), 32'(od[0][7:0]), e0);
    if (e1 >= 0) chk($sformatf("s%0d d1 directed read", stepn), 32'(od[1][7:0]), e1);
    if (ec >= 0) chk($sformatf("s%0d directed count", stepn), 32'(oc[0]), ec);
    if (ee >= 0) chk($sformatf("s%0d directed err", stepn), 32'(oe[0]), ee);
    if (rs) begin
      mreset();
    end else begin
      if ((ret && sz == 0) || (iss && !acc)) merr = 1'b1;
      if (fl) mrf[fa] = ld;
      if (ret && sz > 0) void'(mq.pop_front());
      if (acc) mq.push_back('{live: 1'b1, addr: ia});
      if (we) mrf[wa] = din;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input int e0, input int e1, input int ec, input int ee);
    step(0, 0, 4'd1, 8'h00, 0, 4'd0, 0, 8'h00, a, 4'd5, e0, e1, ec, ee);
  endtask

  task automatic iss(input logic [3:0] a);
    step(0, 0, 4'd1, 8'h00, 1, a, 0, 8'h00, a, 4'd5, -1, -1, -1, -1);
  endtask

  task automatic lret(input logic [7:0] d);
    step(0, 0, 4'd1, 8'h00, 0, 4'd0, 1, d, 4'd0, 4'd5, -1, -1, -1, -1);
  endtask

  task automatic do_reset();
    step(1, 0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h00, 4'd0, 4'd1, -1, -1, -1, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if0.WriteEn = 0; if0.Waddr = 0; if0.DataIn = 0; if0.LoadIssue = 0; if0.LoadAddr = 0;
    if0.LoadRet = 0; if0.LoadData = 0; if0.Raddr = 0;
    if1.WriteEn = 0; if1.Waddr = 0; if1.DataIn = 0; if1.LoadIssue = 0; if1.LoadAddr = 0;
    if1.LoadRet = 0; if1.LoadData = 0; if1.Raddr = 0;
    repeat (2) @(posedge clk);
    #1;
    mreset();

    // Reset state, then write bypass and array read-back.
    step(1, 0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h00, 4'd0, 4'd1, -1, -1, 0, 0);
    rd(4'd3, 0, 0, 0, 0);
    step(0, 1, 4'd3, 8'h5A, 0, 4'd0, 0, 8'h00, 4'd3, 4'd3, 8'h5A, 8'h5A, -1, -1);
    rd(4'd3, 8'h5A, 8'h5A, 0, -1);

    // Three loads in flight, returned in order.
    iss(4'd2); iss(4'd5); iss(4'd7);
    rd(4'd5, -1, -1, 3, -1);
    lret(8'h11); lret(8'h22); lret(8'h33);
    rd(4'd2, 8'h11, 8'h11, 0, -1);
    rd(4'd5, 8'h22, 8'h22, 0, -1);
    rd(4'd7, 8'h33, 8'h33, 0, -1);

    // ALU write kills an outstanding load.
    iss(4'd4);
    step(0, 1, 4'd4, 8'hAA, 0, 4'd0, 0, 8'h00, 4'd4, 4'd4, 8'hAA, 8'hAA, 1, -1);
    lret(8'hFF);
    rd(4'd4, 8'hAA, 8'hAA, 0, -1);

    // Newer load to the same register supersedes the older one.
    iss(4'd6); iss(4'd6);
    lret(8'h01);
    rd(4'd6, 8'h00, 8'h00, 1, -1);
    lret(8'h02);
    rd(4'd6, 8'h02, 8'h02, 0, -1);

    // Overflow, reset clearing, underflow.
    iss(4'd8); iss(4'd9); iss(4'd10); iss(4'd11);
    rd(4'd8, -1, -1, 4, 0);
    iss(4'd12);
    rd(4'd8, -1, -1, 4, 1);
    do_reset();
    rd(4'd8, 0, 0, 0, 0);
    lret(8'h55);
    rd(4'd8, 0, 0, 0, 1);
    do_reset();

    // Register 0 behaviour differs between the two instances.
    step(0, 1, 4'd0, 8'h77, 0, 4'd0, 0, 8'h00, 4'd0, 4'd0, 8'h77, 8'h00, -1, -1);
    rd(4'd0, 8'h77, 8'h00, 0, -1);
    iss(4'd0);
    rd(4'd0, 8'h77, 8'h00, 1, -1);
    lret(8'h99);
    rd(4'd0, 8'h99, 8'h00, 0, 0);

    // Random traffic with address collisions, full/empty edges and rare resets.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 7)), 8'($urandom),
           ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0), 8'($urandom),
           4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), -1, -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
